spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning frame word width in bits (legal 4..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning shift order (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have port clk  input  1  system clock; all logic rising-edge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports sclk, cs, mosi  input  1 each  raw SPI pins; cs active-low; asynchronous to clk.
REQ-006 SHALL have port mode  input  2  SPI mode; mode[1] = CPOL, mode[0] = CPHA.
REQ-007 SHALL have ports tx_data  input  DATA_W  and tx_valid  input  1, plus tx_ready  output  1: the transmit word handshake.
REQ-008 SHALL have ports rx_data  output  DATA_W  and rx_valid  output  1, plus rx_ready  input  1: the receive word handshake.
REQ-009 SHALL have ports miso  output  1 and miso_oe  output  1 (miso_oe high only while a frame is active).
REQ-010 SHALL have ports rx_overrun  output  1 (one-clk pulse) and busy  output  1 (high in ACTIVE).

Function
REQ-011 SHALL pass sclk, cs and mosi through 2-flop synchronizers; sclk edges are detected on the synchronized value. Usable only with clk >= 8x sclk.
REQ-012 SHALL implement FSM states IDLE and ACTIVE. IDLE->ACTIVE on synchronized cs falling. ACTIVE->IDLE on synchronized cs rising.
REQ-013 SHALL latch mode on IDLE->ACTIVE; mode changes during ACTIVE are ignored.
REQ-014 SHALL sample mosi on the leading sclk edge when CPHA=0 and on the trailing edge when CPHA=1. Leading edge is rising for CPOL=0 and falling for CPOL=1. MISO shifts on the opposite edge.
REQ-015 SHALL load the tx shift register at frame start and at every word boundary, as follows:
- tx_valid high: load tx_data, consume it (tx_ready pulses one clk).
- tx_valid low: load all-zeros.
- CPHA=0: the first bit is on miso in the clk after the load.
REQ-016 SHALL count sampled bits 0..DATA_W-1. On the DATA_W-th sample:
- rx_data is updated in bit order per MSB_FIRST.
- rx_valid rises 1 clk after that sample is registered.
- the count wraps to 0, so back-to-back words work within one cs frame.
REQ-017 SHALL hold rx_valid and rx_data until rx_ready is high in a clk cycle where rx_valid is high; rx_valid falls the following clk.
REQ-018 SHALL, when a word completes while rx_valid is still high, keep the old rx_data, drop the new word, and pulse rx_overrun for 1 clk.
REQ-019 SHALL, when a word completes in the same clk that rx_ready accepts the old word, accept the new word with no overrun.
REQ-020 SHALL, on cs deasserting mid-word, discard the partial word, clear the count and go to IDLE; rx_valid/rx_data are unaffected.
REQ-021 SHALL drive miso to 0 whenever miso_oe is low.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force:
- FSM to IDLE, count to 0, shift registers to 0, synchronizers to idle values (cs=1, sclk=0).
- outputs: rx_data=0, rx_valid=0, tx_ready=0, miso=0, miso_oe=0, rx_overrun=0, busy=0.
REQ-023 SHALL, after rst_n rises, ignore a frame whose cs was already low; the first frame starts on a subsequent cs falling edge.

Configuration
REQ-024 SHALL support macro SPI_PERIPHERAL_FRAME_CNT_EN.
- Defined: adds output frame_cnt[15:0], reset 0, incremented once per completed (non-aborted) word, including overrun-dropped words; wraps 0xFFFF->0.
- Undefined: no port and no counter logic.

Structure
REQ-025 SHALL take from shared package spi_pkg: FSM state enum (IDLE, ACTIVE), mode constants (MODE0..MODE3), and the synchronizer depth constant SYNC_STAGES=2.
REQ-026 SHALL instantiate sub-module spi_sync (SYNC_STAGES-flop synchronizer, reset value parameter) once per asynchronous pin.

Verification
REQ-027 SHALL cover: mode 0, DATA_W=8, MSB_FIRST=1, master sends 0xA5 with tx_data=0x3C preloaded -> rx_data=0xA5, rx_valid=1; master receives 0x3C on miso.
REQ-028 SHALL cover: modes 1, 2, 3 each, master sends 0x5A -> rx_data=0x5A every mode; MISO transitions only on the non-sampling edge.
REQ-029 SHALL cover: one cs frame of 3 words 0x11,0x22,0x33 with rx_ready held high -> three rx_valid pulses in that order, rx_overrun never asserted.
REQ-030 SHALL cover: rx_ready held low, two words 0x01 then 0x02 -> rx_data stays 0x01; one rx_overrun pulse; frame_cnt=2 with SPI_PERIPHERAL_FRAME_CNT_EN defined.
REQ-031 SHALL cover: cs raised after 5 of 8 bits, then full frame 0xC3 -> no rx_valid for the aborted word; next rx_data=0xC3.
REQ-032 SHALL cover: rst_n pulsed low mid-word -> all outputs 0 immediately; next full frame 0x7E received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI peripheral slice.
// Holds the FSM state enum, the four SPI mode encodings, the synchronizer
// depth and a small helper that selects the leading sclk edge for a CPOL.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spiState_t;

    // Mode encoding: bit 1 is CPOL (sclk idle level), bit 0 is CPHA.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int SYNC_STAGES = 2;

    // The leading edge leaves the idle level: rising when idle low, falling when idle high.
    // Passing the inverted CPOL gives the trailing edge.
    function automatic logic leadingEdge(input logic cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer for one asynchronous pin.
// RESET_VAL is the idle level of the pin so that reset does not fake an edge.
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES    = SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] stages_q;

    // Shift the raw pin through the flop chain; the last flop is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages_q <= {STAGES{RESET_VAL}};
        end else begin
            stages_q <= {stages_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = stages_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI slave with oversampled pins, all four SPI modes,
// back-to-back words inside one cs frame and valid/ready word handshakes.
// Optional build macro: SPI_PERIPHERAL_FRAME_CNT_EN adds output frame_cnt[15:0],
// a wrapping count of completed words (overrun-dropped words included).
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              miso,
    output logic              miso_oe,
    output logic              rx_overrun,
    output logic              busy
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [1:0]        SETTLED  = 2'(SYNC_STAGES);

    logic sclkS;
    logic csS;
    logic mosiS;

    spiState_t         state_q;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [DATA_W-1:0] rxShift_q;
    logic [DATA_W-1:0] rxShift_d;
    logic [DATA_W-1:0] txShift_q;
    logic              misoBit_q;
    logic              misoOe_q;
    logic              busy_q;
    logic              txReady_q;
    logic              sclkPrev_q;
    logic              csPrev_q;
    logic [1:0]        settleCnt_q;
    logic              armed_q;
    logic              pend_q;
    logic [DATA_W-1:0] pendWord_q;
    logic [DATA_W-1:0] rxData_q;
    logic              rxValid_q;
    logic              rxOverrun_q;
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
    logic [15:0]       frameCnt_q;
`endif

    logic              sclkRise;
    logic              sclkFall;
    logic              leadEdge;
    logic              trailEdge;
    logic              sampleEdge;
    logic              shiftEdge;
    logic              wordDone;
    logic [DATA_W-1:0] loadWord;

    // Bit that goes on the wire first from a freshly loaded word.
    function automatic logic outBit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    // Word left after the current output bit has been sent.
    function automatic logic [DATA_W-1:0] shiftOut(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // cs idles high, sclk and mosi idle low; reset values match so reset creates no edges.
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncSclk (
        .clk(clk), .rst_n(rst_n), .async_i(sclk), .sync_o(sclkS)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncCs (
        .clk(clk), .rst_n(rst_n), .async_i(cs), .sync_o(csS)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncMosi (
        .clk(clk), .rst_n(rst_n), .async_i(mosi), .sync_o(mosiS)
    );

    // Decode synchronized sclk edges into sample/shift strobes for the latched mode.
    always_comb begin
        sclkRise   = sclkS & ~sclkPrev_q;
        sclkFall   = ~sclkS & sclkPrev_q;
        leadEdge   = leadingEdge(mode_q[1], sclkRise, sclkFall);
        trailEdge  = leadingEdge(~mode_q[1], sclkRise, sclkFall);
        sampleEdge = mode_q[0] ? trailEdge : leadEdge;
        shiftEdge  = mode_q[0] ? leadEdge : trailEdge;
        wordDone   = (state_q == ACTIVE) && !csS && sampleEdge && (bitCnt_q == LAST_BIT);
        loadWord   = tx_valid ? tx_data : '0;
        if (MSB_FIRST != 0) begin
            rxShift_d = {rxShift_q[DATA_W-2:0], mosiS};
        end else begin
            rxShift_d = {mosiS, rxShift_q[DATA_W-1:1]};
        end
    end

    // Frame FSM plus the shift datapath: start on cs falling, shift on sclk edges, stop on cs rising.
    // A frame already in progress at reset release is skipped until cs has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE0;
            bitCnt_q    <= '0;
            rxShift_q   <= '0;
            txShift_q   <= '0;
            misoBit_q   <= 1'b0;
            misoOe_q    <= 1'b0;
            busy_q      <= 1'b0;
            txReady_q   <= 1'b0;
            sclkPrev_q  <= 1'b0;
            csPrev_q    <= 1'b1;
            settleCnt_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclkPrev_q <= sclkS;
            csPrev_q   <= csS;
            txReady_q  <= 1'b0;
            if (settleCnt_q != SETTLED) begin
                settleCnt_q <= settleCnt_q + 2'd1;
            end else if (csS) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (armed_q && csPrev_q && !csS) begin
                        state_q   <= ACTIVE;
                        mode_q    <= mode;
                        busy_q    <= 1'b1;
                        misoOe_q  <= 1'b1;
                        bitCnt_q  <= '0;
                        rxShift_q <= '0;
                        txReady_q <= tx_valid;
                        if (mode[0]) begin
                            txShift_q <= loadWord;
                            misoBit_q <= 1'b0;
                        end else begin
                            txShift_q <= shiftOut(loadWord);
                            misoBit_q <= outBit(loadWord);
                        end
                    end
                end
                ACTIVE: begin
                    if (csS) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        misoOe_q  <= 1'b0;
                        misoBit_q <= 1'b0;
                        bitCnt_q  <= '0;
                        rxShift_q <= '0;
                        txShift_q <= '0;
                    end else begin
                        if (sampleEdge) begin
                            rxShift_q <= rxShift_d;
                            if (bitCnt_q == LAST_BIT) begin
                                bitCnt_q <= '0;
                                if (mode_q[0]) begin
                                    txShift_q <= loadWord;
                                    txReady_q <= tx_valid;
                                end
                            end else begin
                                bitCnt_q <= bitCnt_q + 1'b1;
                            end
                        end
                        if (shiftEdge) begin
                            if (!mode_q[0] && (bitCnt_q == '0)) begin
                                txShift_q <= shiftOut(loadWord);
                                misoBit_q <= outBit(loadWord);
                                txReady_q <= tx_valid;
                            end else begin
                                txShift_q <= shiftOut(txShift_q);
                                misoBit_q <= outBit(txShift_q);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Receive handshake: a finished word lands one clk later unless the previous word is still unread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pendWord_q  <= '0;
            rxData_q    <= '0;
            rxValid_q   <= 1'b0;
            rxOverrun_q <= 1'b0;
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
            frameCnt_q  <= '0;
`endif
        end else begin
            pend_q      <= wordDone;
            rxOverrun_q <= 1'b0;
            if (wordDone) begin
                pendWord_q <= rxShift_d;
            end
            if (pend_q) begin
                if (rxValid_q && !rx_ready) begin
                    rxOverrun_q <= 1'b1;
                end else begin
                    rxData_q  <= pendWord_q;
                    rxValid_q <= 1'b1;
                end
            end else if (rxValid_q && rx_ready) begin
                rxValid_q <= 1'b0;
            end
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
            if (pend_q) begin
                frameCnt_q <= frameCnt_q + 16'd1;
            end
`endif
        end
    end

    assign tx_ready   = txReady_q;
    assign rx_data    = rxData_q;
    assign rx_valid   = rxValid_q;
    assign rx_overrun = rxOverrun_q;
    assign busy       = busy_q;
    assign miso_oe    = misoOe_q;
    assign miso       = misoOe_q & misoBit_q;
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
    assign frame_cnt  = frameCnt_q;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed bench acting as SPI master for spi_peripheral.
// Half sclk period is H clk cycles; all pins change on clk falling edges.
module tb_spi_peripheral;
    import spi_pkg::*;

    localparam int H = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       sclk     = 1'b0;
    logic       cs       = 1'b1;
    logic       mosi     = 1'b0;
    logic [1:0] mode     = MODE0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       rx_overrun;
    logic       busy;
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int         total   = 0;
    int         bad     = 0;
    int         misoBad = 0;
    int         ovCnt   = 0;
    logic [7:0] accQ[$];

    always #5 clk = ~clk;

    spi_peripheral #(.DATA_W(8), .MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .mode(mode),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .miso(miso), .miso_oe(miso_oe), .rx_overrun(rx_overrun), .busy(busy)
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    // Record every accepted word and every overrun pulse.
    always @(negedge clk) begin
        if (rx_overrun) ovCnt++;
        if (rx_valid && rx_ready) accQ.push_back(rx_data);
    end

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Put sclk at the idle level of the new mode, drop cs and optionally offer a tx word.
    task automatic startFrame(input logic [1:0] m, input logic [7:0] txWord, input logic txLoad);
        int n;
        mode = m;
        sclk = m[1];
        waitClks(4);
        tx_data  = txWord;
        tx_valid = txLoad;
        cs = 1'b0;
        if (txLoad) begin
            n = 0;
            while (!tx_ready && n < 12) begin
                waitClks(1);
                n++;
            end
            checkOutput("tx_ready_pulse", {31'd0, tx_ready}, 32'd1);
            tx_valid = 1'b0;
        end
        waitClks(H);
    endtask

    task automatic endFrame();
        waitClks(H);
        cs = 1'b1;
        waitClks(H);
    endtask

    // Clock nBits master bits out on mosi, collecting miso and noting miso moves across a sampling edge.
    task automatic applyStimulus(input logic [7:0] txWord, input int nBits, output logic [7:0] rxWord);
        logic a;
        rxWord = 8'h00;
        for (int i = 0; i < nBits; i++) begin
            if (!mode[0]) begin
                mosi = txWord[7-i];
                waitClks(H);
                a = miso;
                rxWord = {rxWord[6:0], miso};
                sclk = ~mode[1];
                waitClks(H);
                if (miso !== a) misoBad++;
                sclk = mode[1];
            end else begin
                sclk = ~mode[1];
                mosi = txWord[7-i];
                waitClks(H);
                a = miso;
                rxWord = {rxWord[6:0], miso};
                sclk = mode[1];
                waitClks(H);
                if (miso !== a) misoBad++;
            end
        end
    endtask

    task automatic acceptWord();
        rx_ready = 1'b1;
        waitClks(1);
        rx_ready = 1'b0;
        waitClks(1);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] modeTx [3];
        int base;
        int ov0;
        modeTx[0] = 8'hC3;
        modeTx[1] = 8'h69;
        modeTx[2] = 8'h0F;

        // Reset with cs already low: outputs clear, and that stale frame must be skipped.
        cs = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_rx_data", {24'd0, rx_data}, 32'h0);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        checkOutput("rst_miso", {31'd0, miso}, 32'd0);
        checkOutput("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        checkOutput("rst_rx_overrun", {31'd0, rx_overrun}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        waitClks(3);
        rst_n = 1'b1;
        waitClks(12);
        checkOutput("stale_cs_busy", {31'd0, busy}, 32'd0);
        checkOutput("stale_cs_miso_oe", {31'd0, miso_oe}, 32'd0);
        cs = 1'b1;
        waitClks(6);

        // Mode 0: master sends 0xA5, slave answers with preloaded 0x3C.
        startFrame(MODE0, 8'h3C, 1'b1);
        checkOutput("m0_busy", {31'd0, busy}, 32'd1);
        checkOutput("m0_miso_oe", {31'd0, miso_oe}, 32'd1);
        applyStimulus(8'hA5, 8, got);
        endFrame();
        checkOutput("m0_rx_data", {24'd0, rx_data}, 32'hA5);
        checkOutput("m0_rx_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("m0_master_rx", {24'd0, got}, 32'h3C);
        checkOutput("m0_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("m0_idle_oe", {31'd0, miso_oe}, 32'd0);
        checkOutput("m0_idle_miso", {31'd0, miso}, 32'd0);
        acceptWord();
        checkOutput("m0_rx_valid_clr", {31'd0, rx_valid}, 32'd0);

        // Modes 1..3: master sends 0x5A, each with its own tx word.
        for (int m = 1; m < 4; m++) begin
            startFrame(2'(m), modeTx[m-1], 1'b1);
            applyStimulus(8'h5A, 8, got);
            endFrame();
            checkOutput($sformatf("mode%0d_rx_data", m), {24'd0, rx_data}, 32'h5A);
            checkOutput($sformatf("mode%0d_rx_valid", m), {31'd0, rx_valid}, 32'd1);
            checkOutput($sformatf("mode%0d_master_rx", m), {24'd0, got}, {24'd0, modeTx[m-1]});
            checkOutput($sformatf("mode%0d_miso_stable", m), misoBad, 32'd0);
            acceptWord();
        end

        // Three words in one frame with rx_ready held high.
        rx_ready = 1'b1;
        waitClks(2);
        base = accQ.size();
        ov0  = ovCnt;
        startFrame(MODE0, 8'h00, 1'b0);
        applyStimulus(8'h11, 8, got);
        applyStimulus(8'h22, 8, got);
        applyStimulus(8'h33, 8, got);
        endFrame();
        rx_ready = 1'b0;
        checkOutput("b2b_count", accQ.size() - base, 32'd3);
        for (int k = 0; k < 3; k++) begin
            got = (accQ.size() > base + k) ? accQ[base+k] : 8'hxx;
            checkOutput($sformatf("b2b_word%0d", k), {24'd0, got}, 32'h11 * (k + 1));
        end
        checkOutput("b2b_no_overrun", ovCnt - ov0, 32'd0);
        checkOutput("b2b_rx_valid", {31'd0, rx_valid}, 32'd0);

        // Overrun: second word arrives while the first is unread.
        ov0 = ovCnt;
        startFrame(MODE0, 8'h00, 1'b0);
        applyStimulus(8'h01, 8, got);
        applyStimulus(8'h02, 8, got);
        endFrame();
        checkOutput("ovr_rx_data", {24'd0, rx_data}, 32'h01);
        checkOutput("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("ovr_pulses", ovCnt - ov0, 32'd1);
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
        checkOutput("ovr_frame_cnt", {16'd0, frame_cnt}, 32'd9);
`endif
        acceptWord();

        // Abort after 5 bits, then a clean 0xC3 frame.
        startFrame(MODE0, 8'h00, 1'b0);
        applyStimulus(8'hFF, 5, got);
        endFrame();
        checkOutput("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
        startFrame(MODE0, 8'h00, 1'b0);
        applyStimulus(8'hC3, 8, got);
        endFrame();
        checkOutput("after_abort_rx_data", {24'd0, rx_data}, 32'hC3);
        checkOutput("after_abort_rx_valid", {31'd0, rx_valid}, 32'd1);
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
        checkOutput("after_abort_frame_cnt", {16'd0, frame_cnt}, 32'd10);
`endif

        // Reset mid-word while the 0xC3 word is still pending.
        startFrame(MODE0, 8'h00, 1'b0);
        applyStimulus(8'hF0, 4, got);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rx_data", {24'd0, rx_data}, 32'h0);
        checkOutput("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
        checkOutput("midrst_miso", {31'd0, miso}, 32'd0);
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
        checkOutput("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
        waitClks(2);
        rst_n = 1'b1;
        waitClks(12);
        checkOutput("midrst_stale_busy", {31'd0, busy}, 32'd0);
        cs = 1'b1;
        waitClks(H);
        startFrame(MODE0, 8'h00, 1'b0);
        applyStimulus(8'h7E, 8, got);
        endFrame();
        checkOutput("post_rst_rx_data", {24'd0, rx_data}, 32'h7E);
        checkOutput("post_rst_rx_valid", {31'd0, rx_valid}, 32'd1);
`ifdef SPI_PERIPHERAL_FRAME_CNT_EN
        checkOutput("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
